// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and constants for the Wishbone memory arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / BUSY)
//   - MAX_MASTERS : upper bound on the number of upstream masters
//   - PERF_W      : width of each performance counter
//   - idx_width() : bits needed to index n masters (at least 1)
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned PERF_W      = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first asserted request
//   found when scanning upward from i_ptr, wrapping modulo N_MASTERS.
//
//   Ports:
//     i_req   [N_MASTERS-1:0] : request vector, one bit per master
//     i_ptr   [IDX_W-1:0]     : index with highest priority this round
//     o_valid                 : at least one request is asserted
//     o_idx   [IDX_W-1:0]     : index of the chosen master (0 when !o_valid)
// -----------------------------------------------------------------------------
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned IDX_W     = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_idx
);

  localparam int unsigned N_SCAN = (N_MASTERS < MAX_MASTERS) ? N_MASTERS : MAX_MASTERS;

  // Rotate the request vector so that bit 0 corresponds to master i_ptr;
  // the first set bit k then maps back to master (i_ptr + k) mod N.
  logic [N_MASTERS-1:0] w_rot;
  logic [IDX_W:0]       w_sum;

  assign w_rot = N_MASTERS'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < N_SCAN; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_ptr} + (IDX_W+1)'(k);
        if (w_sum >= (IDX_W+1)'(N_SCAN)) begin
          w_sum = w_sum - (IDX_W+1)'(N_SCAN);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
//   N-master to one-slave Wishbone arbiter merging cache miss traffic onto a
//   single memory bus. Round-robin grant, held for the whole bus cycle; ACK/RTY
//   are routed only to the granted master, read data is broadcast.
//
//   Optional feature macro: MEMARB_PERF_EN
//     defined   : per-master saturating grant and wait-cycle counters
//     undefined : perf_grants / perf_waits tied to 0 (ports remain)
//
//   Ports:
//     CLK, RST            : clock, synchronous active-high reset
//     m_adr/m_dat_m/m_sel : packed per-master address, write data, byte sel
//     m_cyc/m_stb/m_we    : per-master cycle, strobe, write enable
//     m_dat_s             : read data, broadcast to all masters
//     m_ack/m_rty         : per-master acknowledge / retry
//     s_adr..s_we         : downstream master-side signals
//     s_dat_s/s_ack/s_rty : downstream read data, acknowledge, retry
//     perf_grants         : per-master grant counters (PERF_W each)
//     perf_waits          : per-master wait-cycle counters (PERF_W each)
// -----------------------------------------------------------------------------
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_m,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_sel,
  input  logic [N_MASTERS-1:0]          m_cyc,
  input  logic [N_MASTERS-1:0]          m_stb,
  input  logic [N_MASTERS-1:0]          m_we,
  output logic [DATA_W-1:0]             m_dat_s,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_rty,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_m,
  output logic [DATA_W/8-1:0]           s_sel,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  input  logic [DATA_W-1:0]             s_dat_s,
  input  logic                          s_ack,
  input  logic                          s_rty,
  output logic [N_MASTERS*PERF_W-1:0]   perf_grants,
  output logic [N_MASTERS*PERF_W-1:0]   perf_waits
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = idx_width(N_MASTERS);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_gnt_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_nxt;
  logic [IDX_W-1:0] w_ptr_inc;

  logic [N_MASTERS-1:0] w_req;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_pick_idx;

  // Signals of the currently indexed master, independent of FSM state
  logic [ADDR_W-1:0] w_g_adr;
  logic [DATA_W-1:0] w_g_dat;
  logic [SEL_W-1:0]  w_g_sel;
  logic              w_g_cyc;
  logic              w_g_stb;
  logic              w_g_we;

  assign w_req = m_cyc & m_stb;

  rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Wrap explicitly so non-power-of-two N and N=1 stay in range
  assign w_ptr_inc = (r_gnt_idx == IDX_W'(N_MASTERS - 1)) ? '0 : r_gnt_idx + IDX_W'(1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_gnt_nxt;
      r_rr_ptr  <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_idx;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = w_pick_idx;
        end
      end
      BUSY: begin
        // Completion takes precedence over a simultaneous CYC drop
        if (s_ack || s_rty) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_ptr_inc;
        end else if (!w_g_cyc) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Granted-master mux and response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    w_g_adr = '0;
    w_g_dat = '0;
    w_g_sel = '0;
    w_g_cyc = 1'b0;
    w_g_stb = 1'b0;
    w_g_we  = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (r_gnt_idx == IDX_W'(i)) begin
        w_g_adr = m_adr[i*ADDR_W +: ADDR_W];
        w_g_dat = m_dat_m[i*DATA_W +: DATA_W];
        w_g_sel = m_sel[i*SEL_W +: SEL_W];
        w_g_cyc = m_cyc[i];
        w_g_stb = m_stb[i];
        w_g_we  = m_we[i];
      end
    end
  end

  always_comb begin
    s_adr   = '0;
    s_dat_m = '0;
    s_sel   = '0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    m_ack   = '0;
    m_rty   = '0;
    if (r_state == BUSY) begin
      s_adr   = w_g_adr;
      s_dat_m = w_g_dat;
      s_sel   = w_g_sel;
      s_cyc   = w_g_cyc;
      s_stb   = w_g_stb;
      s_we    = w_g_we;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (r_gnt_idx == IDX_W'(i)) begin
          m_ack[i] = s_ack;
          m_rty[i] = s_rty;
        end
      end
    end
  end

  assign m_dat_s = s_dat_s;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef MEMARB_PERF_EN
  logic [PERF_W-1:0] r_perf_grants [N_MASTERS];
  logic [PERF_W-1:0] r_perf_waits  [N_MASTERS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        r_perf_grants[i] <= '0;
        r_perf_waits[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if ((r_state == IDLE) && w_pick_valid && (w_pick_idx == IDX_W'(i)) &&
            (r_perf_grants[i] != '1)) begin
          r_perf_grants[i] <= r_perf_grants[i] + PERF_W'(1);
        end
        // A master waits whenever it requests without owning the bus
        if (w_req[i] && !((r_state == BUSY) && (r_gnt_idx == IDX_W'(i))) &&
            (r_perf_waits[i] != '1)) begin
          r_perf_waits[i] <= r_perf_waits[i] + PERF_W'(1);
        end
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    perf_waits  = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      perf_grants[i*PERF_W +: PERF_W] = r_perf_grants[i];
      perf_waits[i*PERF_W +: PERF_W]  = r_perf_waits[i];
    end
  end
`else
  assign perf_grants = '0;
  assign perf_waits  = '0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
//   Self-checking bench for wb_mem_arbiter with four masters. A transaction-
//   level reference model (busy flag, owner, priority pointer, counters)
//   predicts every output each cycle; directed scenarios add explicit checks.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat_m;
  logic [N*SW-1:0]   m_sel;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [DW-1:0]     m_dat_s;
  logic [N-1:0]      m_ack, m_rty;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_m;
  logic [SW-1:0]     s_sel;
  logic              s_cyc, s_stb, s_we;
  logic [DW-1:0]     s_dat_s;
  logic              s_ack, s_rty;
  logic [N*32-1:0]   perf_grants, perf_waits;

  logic [AW-1:0] adr [N];
  logic [DW-1:0] dat [N];
  logic [SW-1:0] sel [N];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          mb;
  int          mg, mp;
  logic [31:0] mgr [N];
  logic [31:0] mwt [N];

  always #5 CLK = ~CLK;

  always_comb begin
    m_adr   = '0;
    m_dat_m = '0;
    m_sel   = '0;
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = adr[i];
      m_dat_m[i*DW +: DW] = dat[i];
      m_sel[i*SW +: SW]   = sel[i];
    end
  end

  wb_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .m_adr(m_adr), .m_dat_m(m_dat_m), .m_sel(m_sel),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_s(m_dat_s), .m_ack(m_ack), .m_rty(m_rty),
    .s_adr(s_adr), .s_dat_m(s_dat_m), .s_sel(s_sel),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_dat_s(s_dat_s), .s_ack(s_ack), .s_rty(s_rty),
    .perf_grants(perf_grants), .perf_waits(perf_waits)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bus ownership at the clock edge: reset clears, a free bus goes to the
  // requester at the smallest rotational distance from the pointer, an owner
  // leaves on ack/retry (pointer moves past it) or on dropping CYC.
  task automatic model_update();
    int best, bestd, d;
    if (RST) begin
      mb = 1'b0; mg = 0; mp = 0;
      for (int i = 0; i < N; i++) begin mgr[i] = '0; mwt[i] = '0; end
    end else begin
      for (int i = 0; i < N; i++)
        if (m_cyc[i] && m_stb[i] && !(mb && mg == i) && mwt[i] != 32'hFFFF_FFFF)
          mwt[i] = mwt[i] + 1;
      if (!mb) begin
        best = N; bestd = N;
        for (int i = 0; i < N; i++) begin
          d = (i + N - mp) % N;
          if (m_cyc[i] && m_stb[i] && d < bestd) begin bestd = d; best = i; end
        end
        if (best < N) begin
          mb = 1'b1; mg = best;
          if (mgr[best] != 32'hFFFF_FFFF) mgr[best] = mgr[best] + 1;
        end
      end else if (s_ack || s_rty) begin
        mb = 1'b0; mp = (mg + 1) % N;
      end else if (!m_cyc[mg]) begin
        mb = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [174:0] es;
    logic [N-1:0] ea, er;
    logic [127:0] epg, epw;
    es = '0; ea = '0; er = '0;
    if (mb) begin
      es = {adr[mg], dat[mg], sel[mg], m_we[mg], m_cyc[mg], m_stb[mg]};
      ea[mg] = s_ack;
      er[mg] = s_rty;
    end
    chk("s_bus", {s_adr, s_dat_m, s_sel, s_we, s_cyc, s_stb}, es);
    chk("m_resp", {m_ack, m_rty}, {ea, er});
    chk("m_dat_s", m_dat_s, s_dat_s);
    for (int i = 0; i < N; i++) begin
      epg[i*32 +: 32] = mgr[i];
      epw[i*32 +: 32] = mwt[i];
    end
`ifdef MEMARB_PERF_EN
    chk("perf_grants", perf_grants, epg);
    chk("perf_waits", perf_waits, epw);
`else
    chk("perf_grants", perf_grants, 0);
    chk("perf_waits", perf_waits, 0);
`endif
  endtask

  task automatic step_pre(); #1; check_outputs(); endtask
  task automatic tick(); @(posedge CLK); model_update(); #1; endtask
  task automatic cycle(); step_pre(); tick(); endtask

  function automatic logic [DW-1:0] rnd_dat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int nack, total;
    int cnt [N];
    logic [31:0] exp_w1, exp_g1;
    logic [N-1:0] done;

    RST = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_rty = 1'b0; s_dat_s = '0;
    for (int i = 0; i < N; i++) begin adr[i] = '0; dat[i] = '0; sel[i] = '0; end
    tick();

    // Reset state
    cycle();
    RST = 1'b0;
    step_pre();
    chk("reset_s", {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_m}, 0);
    chk("reset_m", {m_ack, m_rty}, 0);
    tick();

    // Single master read
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    adr[0] = 28'h0000100; sel[0] = '1; dat[0] = rnd_dat();
    step_pre(); chk("single_stb_idle", s_stb, 0); tick();
    step_pre(); chk("single_stb_busy", s_stb, 1); chk("single_adr", s_adr, 28'h0000100); tick();
    s_ack = 1'b1; s_dat_s = {16{8'hA5}};
    step_pre(); chk("single_ack", m_ack, 4'b0001); chk("single_dat", m_dat_s, {16{8'hA5}}); tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    cycle();

    // Simultaneous requests after reset alternate 0,1,0,1 with one idle gap
    RST = 1'b1; cycle(); RST = 1'b0;
    for (int i = 0; i < 2; i++) begin adr[i] = AW'($urandom()); dat[i] = rnd_dat(); end
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      s_ack = mb; s_dat_s = rnd_dat();
      step_pre();
      chk("alt_scyc", s_cyc, (k % 2) == 1);
      if (m_ack != '0) begin
        chk("alt_order", m_ack, (nack % 2 == 0) ? 4'b0001 : 4'b0010);
        nack++;
      end
      tick();
    end
    chk("alt_count", nack, 4);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    cycle();

    // Four continuous requesters: 8 completions, two per master
    RST = 1'b1; cycle(); RST = 1'b0;
    m_cyc = '1; m_stb = '1; total = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 40 && total < 8; k++) begin
      s_ack = mb;
      step_pre();
      for (int i = 0; i < N; i++) if (m_ack[i]) begin cnt[i]++; total++; end
      tick();
    end
    chk("starve_total", total, 8);
    for (int i = 0; i < N; i++) chk("starve_each", cnt[i], 2);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    cycle();

    // Abort by master 1 leaves the pointer at 0, so 1 beats 2 afterwards
    RST = 1'b1; cycle(); RST = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step_pre(); chk("abort_noack", m_ack, 0); tick();
    m_cyc[2:1] = 2'b11; m_stb[2:1] = 2'b11;
    step_pre(); chk("abort_idle", s_cyc, 0); tick();
    s_ack = 1'b1;
    step_pre(); chk("abort_ptr", m_ack, 4'b0010); chk("abort_adr", s_adr, adr[1]); tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    cycle();

    // Reset during BUSY
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    RST = 1'b1;
    step_pre(); chk("rst_busy_scyc", s_cyc, 1); tick();
    step_pre();
    chk("rst_mid_s", {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_m}, 0);
    chk("rst_mid_m", {m_ack, m_rty}, 0);
    chk("rst_mid_pg", perf_grants, 0);
    chk("rst_mid_pw", perf_waits, 0);
    tick();
    RST = 1'b0; m_cyc = '0; m_stb = '0;
    cycle();

    // Master 1 waits behind a master 0 transfer
    RST = 1'b1; cycle(); RST = 1'b0;
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    s_ack = 1'b0; step_pre(); tick();
    s_ack = 1'b1; step_pre(); tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
    step_pre(); tick();
    s_ack = 1'b1; step_pre(); tick();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
    step_pre();
`ifdef MEMARB_PERF_EN
    exp_w1 = 32'd3; exp_g1 = 32'd1;
`else
    exp_w1 = 32'd0; exp_g1 = 32'd0;
`endif
    chk("perf_waits1", perf_waits[63:32], exp_w1);
    chk("perf_grants1", perf_grants[63:32], exp_g1);
    tick();

    // Randomized traffic: masters hold requests until answered, occasional
    // aborts, retries, spurious idle acks and resets
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom_range(0, 5));
      s_ack = (r == 0);
      s_rty = (r == 1) && mb;
      s_dat_s = rnd_dat();
      RST = ($urandom_range(0, 99) == 0);
      if (mb && m_cyc[mg] && !s_ack && !s_rty && $urandom_range(0, 19) == 0) begin
        m_cyc[mg] = 1'b0; m_stb[mg] = 1'b0;
      end
      done = '0;
      if (mb && (s_ack || s_rty)) done[mg] = 1'b1;
      cycle();
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end else if (!m_cyc[i] && $urandom_range(0, 2) == 0) begin
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = 1'($urandom());
          adr[i] = AW'($urandom()); dat[i] = rnd_dat(); sel[i] = SW'($urandom());
        end
      end
    end
    RST = 1'b0; s_ack = 1'b0; s_rty = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
